mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_lsu.sv | 130 +++++++++++++
 tb/tb_mem_lsu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
//   state_e : LSU control states
//   size_e  : access size encoding as presented on req_size
//   err_e   : response error code as presented on resp_err
//   req_t   : request fields latched at the request handshake
package mem_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned ERR_W  = 2;
   localparam int unsigned WSEL_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic [SIZE_W-1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2
   } err_e;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic            we;
      size_e           size;
      logic            is_unsigned;
   } req_t;

   // Number of bytes touched by an access of the given size.
   function automatic logic [3:0] size_bytes(input size_e s);
      case (s)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Thermometer-style width select understood by the memory.
   function automatic logic [WSEL_W-1:0] size_to_widthsel(input size_e s);
      case (s)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extension.
// Masks raw memory data to the access size, then zero- or sign-extends.
//   data_i        : raw little-endian read data from memory
//   size_i        : access size
//   is_unsigned_i : 1 = zero-extend, 0 = sign-extend (ignored for double)
//   data_o        : extended load result
module mem_load_ext
   import mem_pkg::*;
(
   input  logic [XLEN-1:0] data_i,
   input  size_e           size_i,
   input  logic            is_unsigned_i,
   output logic [XLEN-1:0] data_o
);

   logic sign_b, sign_h, sign_w;

   // Replicated bit is forced to 0 for unsigned loads.
   assign sign_b = data_i[7]  & ~is_unsigned_i;
   assign sign_h = data_i[15] & ~is_unsigned_i;
   assign sign_w = data_i[31] & ~is_unsigned_i;

   always_comb begin
      data_o = data_i;
      case (size_i)
         SZ_B:    data_o = {{56{sign_b}}, data_i[7:0]};
         SZ_H:    data_o = {{48{sign_h}}, data_i[15:0]};
         SZ_W:    data_o = {{32{sign_w}}, data_i[31:0]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the pipeline and a byte-addressed memory with
// asynchronous read and synchronous write.
//   clk, reset                    : clock, async active-high reset
//   req_valid/req_ready           : request handshake
//   req_addr/wdata/we/size/unsigned : request payload
//   resp_valid/resp_ready         : response handshake
//   resp_rdata/resp_err           : response payload (held until taken)
//   mem_addr/widthsel/writedata/we : memory request, non-zero only in ACCESS
//   mem_readdata                  : memory read data, captured at end of ACCESS
module mem_lsu
   import mem_pkg::*;
#(
   parameter int unsigned NKB = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic              req_we,
   input  logic [SIZE_W-1:0] req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [ERR_W-1:0]  resp_err,
   output logic [XLEN-1:0]   mem_addr,
   output logic [WSEL_W-1:0] mem_widthsel,
   input  logic [XLEN-1:0]   mem_readdata,
   output logic [XLEN-1:0]   mem_writedata,
   output logic              mem_we
);

   localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(NKB) * XLEN'(1024);

   state_e          state_q, state_d;
   req_t            req_q, req_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   err_e            err_q, err_d;

   size_e           req_size_e;
   logic [XLEN-1:0] req_nbytes;
   err_e            req_err;
   logic [XLEN-1:0] ext_data;
   logic            in_access;

   assign req_size_e = size_e'(req_size);
   assign req_nbytes = XLEN'(size_bytes(req_size_e));

   // Range check subtracts from the memory size instead of adding to the
   // address, so addresses near 2^64 cannot wrap into range.
   always_comb begin
      req_err = ERR_NONE;
      if (req_addr > (MEM_BYTES - req_nbytes)) begin
         req_err = ERR_RANGE;
      end else if ((req_addr & (req_nbytes - XLEN'(1))) != '0) begin
         req_err = ERR_MISALIGN;
      end
   end

   mem_load_ext u_load_ext (
      .data_i        (mem_readdata),
      .size_i        (req_q.size),
      .is_unsigned_i (req_q.is_unsigned),
      .data_o        (ext_data)
   );

   // State and latched request/response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d.addr        = req_addr;
               req_d.wdata       = req_wdata;
               req_d.we          = req_we;
               req_d.size        = req_size_e;
               req_d.is_unsigned = req_unsigned;
               err_d             = req_err;
               rdata_d           = '0;
               state_d           = (req_err == ERR_NONE) ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            rdata_d = req_q.we ? '0 : ext_data;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_access = (state_q == ACCESS);

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   assign mem_addr      = in_access ? req_q.addr : '0;
   assign mem_widthsel  = in_access ? size_to_widthsel(req_q.size) : '0;
   assign mem_writedata = in_access ? req_q.wdata : '0;
   // Gated directly by reset so a reset during ACCESS never issues a write,
   // independent of how quickly the state register clears.
   assign mem_we        = in_access & req_q.we & ~reset;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed, table-driven bench for mem_lsu with a byte-array memory model.
module tb_mem_lsu;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [63:0] mem_addr;
   logic [2:0]  mem_widthsel;
   logic [63:0] mem_readdata;
   logic [63:0] mem_writedata;
   logic        mem_we;

   int checks = 0;
   int errors = 0;

   logic [7:0] bmem [0:2047] = '{default: 8'h00};

   mem_lsu #(.NKB(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_rdata    (resp_rdata),
      .resp_err      (resp_err),
      .mem_addr      (mem_addr),
      .mem_widthsel  (mem_widthsel),
      .mem_readdata  (mem_readdata),
      .mem_writedata (mem_writedata),
      .mem_we        (mem_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: little-endian, async read, sync write of N bytes.
   always_comb begin
      mem_readdata = '0;
      for (int k = 0; k < 8; k++) begin
         if (mem_addr + 64'(k) < 64'd2048)
            mem_readdata[8*k +: 8] = bmem[11'(mem_addr + 64'(k))];
      end
   end

   always @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 8; k++) begin
            if (k < wsel_bytes(mem_widthsel) && (mem_addr + 64'(k) < 64'd2048))
               bmem[11'(mem_addr + 64'(k))] <= mem_writedata[8*k +: 8];
         end
      end
   end

   function automatic int wsel_bytes(input logic [2:0] ws);
      case (ws)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b011:  return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [2:0] exp_wsel(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'b000;
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // One full transaction. Cycle 0 is the handshake cycle; lat is the first
   // cycle index (counted from it) in which resp_valid is observed.
   task automatic do_op(input logic [63:0] addr, input logic [63:0] wdata,
                        input logic we, input logic [1:0] size, input logic uns,
                        input int hold,
                        output logic [63:0] rdata, output logic [1:0] err,
                        output int lat, output int wecnt,
                        output logic [2:0] ws1, output logic [63:0] ad1);
      int g;
      int c;
      @(negedge clk);
      req_addr     = addr;
      req_wdata    = wdata;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_valid    = 1'b1;
      resp_ready   = 1'b0;
      g = 0;
      while (!req_ready && g < 10) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      c     = 1;
      wecnt = 0;
      ws1   = mem_widthsel;
      ad1   = mem_addr;
      while (c < 10) begin
         if (mem_we) wecnt++;
         if (resp_valid) break;
         @(negedge clk);
         c++;
      end
      lat = c;
      if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
      rdata = resp_rdata;
      err   = resp_err;
      for (int h = 0; h < hold; h++) begin
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_rdata", resp_rdata, rdata);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      if (hold > 0) chk("bp_done", 64'(resp_valid), 64'd0);
   endtask

   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] rdata;
      logic [1:0]  err;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   logic [63:0] rd, ad1;
   logic [1:0]  er;
   logic [2:0]  ws1;
   int          lat, wec;
   string       tag;

   initial begin
      vecs[0]  = '{64'h10, 64'hFF, 1'b1, 2'd0, 1'b0, 64'h0, 2'd0};
      vecs[1]  = '{64'h10, 64'h0, 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0};
      vecs[2]  = '{64'h10, 64'h0, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_00FF, 2'd0};
      vecs[3]  = '{64'h8, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd3, 1'b0, 64'h0, 2'd0};
      vecs[4]  = '{64'h8, 64'h0, 1'b0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd0};
      vecs[5]  = '{64'h8, 64'h0, 1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_89AB_CDEF, 2'd0};
      vecs[6]  = '{64'h8, 64'h0, 1'b0, 2'd2, 1'b1, 64'h0000_0000_89AB_CDEF, 2'd0};
      vecs[7]  = '{64'h9, 64'h0, 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFCD, 2'd0};
      vecs[8]  = '{64'hC, 64'h0, 1'b0, 2'd2, 1'b0, 64'h0000_0000_0123_4567, 2'd0};
      vecs[9]  = '{64'h12, 64'hFFFF_8001, 1'b1, 2'd1, 1'b0, 64'h0, 2'd0};
      vecs[10] = '{64'h12, 64'h0, 1'b0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 2'd0};
      vecs[11] = '{64'h12, 64'h0, 1'b0, 2'd1, 1'b1, 64'h0000_0000_0000_8001, 2'd0};
      vecs[12] = '{64'h2, 64'h0, 1'b0, 2'd2, 1'b0, 64'h0, 2'd1};
      vecs[13] = '{64'd2044, 64'h0, 1'b0, 2'd3, 1'b0, 64'h0, 2'd2};
      vecs[14] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 2'd3, 1'b0, 64'h0, 2'd2};
      vecs[15] = '{64'd2046, 64'hBEEF, 1'b1, 2'd1, 1'b0, 64'h0, 2'd0};
      vecs[16] = '{64'd2046, 64'h0, 1'b0, 2'd1, 1'b1, 64'h0000_0000_0000_BEEF, 2'd0};
      vecs[17] = '{64'd2047, 64'h0, 1'b0, 2'd1, 1'b0, 64'h0, 2'd2};
      vecs[18] = '{64'd2040, 64'h0, 1'b0, 2'd3, 1'b0, 64'hBEEF_0000_0000_0000, 2'd0};
      vecs[19] = '{64'h1, 64'hDEAD, 1'b1, 2'd2, 1'b0, 64'h0, 2'd1};
      vecs[20] = '{64'h0, 64'h0, 1'b0, 2'd3, 1'b0, 64'h0, 2'd0};

      reset        = 1'b1;
      req_valid    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_we       = 1'b0;
      req_size     = '0;
      req_unsigned = 1'b0;
      resp_ready   = 1'b0;

      // Reset state.
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wsel", 64'(mem_widthsel), 64'd0);
      chk("rst_mem_wdata", mem_writedata, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Vector table.
      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].uns, 0,
               rd, er, lat, wec, ws1, ad1);
         tag = $sformatf("v%0d", i);
         chk({tag, "_rdata"}, rd, vecs[i].rdata);
         chk({tag, "_err"}, 64'(er), 64'(vecs[i].err));
         chk({tag, "_lat"}, 64'(lat), (vecs[i].err == 2'd0) ? 64'd2 : 64'd1);
         chk({tag, "_we_cycles"}, 64'(wec),
             (vecs[i].we && vecs[i].err == 2'd0) ? 64'd1 : 64'd0);
         chk({tag, "_wsel"}, 64'(ws1),
             (vecs[i].err == 2'd0) ? 64'(exp_wsel(vecs[i].size)) : 64'd0);
         chk({tag, "_maddr"}, ad1, (vecs[i].err == 2'd0) ? vecs[i].addr : 64'd0);
      end

      // Backpressure: response held while resp_ready stays low.
      do_op(64'h8, 64'h0, 1'b0, 2'd3, 1'b0, 5, rd, er, lat, wec, ws1, ad1);
      chk("bp_rdata_final", rd, 64'h0123_4567_89AB_CDEF);
      chk("bp_err", 64'(er), 64'd0);

      // Reset during ACCESS of a store must not write memory.
      do_op(64'h20, 64'h1111_1111_1111_1111, 1'b1, 2'd3, 1'b0, 0, rd, er, lat, wec, ws1, ad1);
      @(negedge clk);
      req_addr  = 64'h20;
      req_wdata = 64'h2222_2222_2222_2222;
      req_we    = 1'b1;
      req_size  = 2'd3;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_access_we", 64'(mem_we), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
      chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);
      chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
      do_op(64'h20, 64'h0, 1'b0, 2'd3, 1'b0, 0, rd, er, lat, wec, ws1, ad1);
      chk("post_rst_load", rd, 64'h1111_1111_1111_1111);
      chk("post_rst_err", 64'(er), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
